// File: rtl/dsp_div.sv
// -----------------------------------------------------------------------------
// dsp_div
// Sequential signed integer divider. It divides two's-complement operands by
// running a radix-2 restoring division on their magnitudes, then restores the
// signs. The quotient is truncated toward zero, and the remainder takes the
// sign of the dividend. Both sides use a valid/ready handshake, and only one
// division is in flight at a time.
//
// Ports
//   i_clk          rising-edge clock
//   i_aresetn      asynchronous active-low reset
//   i_in_valid     operand pair valid
//   o_in_ready     divider can accept operands (IDLE only)
//   i_dividend     signed dividend
//   i_divisor      signed divisor
//   o_out_valid    result valid (DONE only)
//   i_out_ready    downstream accepts result
//   o_quotient     signed quotient, truncated toward zero
//   o_remainder    signed remainder, sign of dividend (or zero)
//   o_div_by_zero  current result is a divide-by-zero
// -----------------------------------------------------------------------------
module dsp_div #(
    parameter int VALUE_WIDTH = 17
) (
    input  logic                   i_clk,
    input  logic                   i_aresetn,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [VALUE_WIDTH-1:0] i_dividend,
    input  logic [VALUE_WIDTH-1:0] i_divisor,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [VALUE_WIDTH-1:0] o_quotient,
    output logic [VALUE_WIDTH-1:0] o_remainder,
    output logic                   o_div_by_zero
);

    localparam int W     = VALUE_WIDTH;
    localparam int CNT_W = (W > 2) ? $clog2(W) : 1;

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABS,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q,     state_d;
    // op_a holds the raw dividend, then its magnitude, and finally acts as the
    // shift register that feeds dividend bits into the partial remainder.
    logic [W-1:0]     op_a_q,      op_a_d;
    logic [W-1:0]     op_b_q,      op_b_d;
    logic             sign_a_q,    sign_a_d;
    logic             sign_b_q,    sign_b_d;
    // The partial remainder is always smaller than |divisor| <= 2^(W-1), so W
    // bits hold it. The extra bit exists only in the shifted trial value.
    logic [W-1:0]     rem_q,       rem_d;
    logic [W-1:0]     quo_q,       quo_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [W-1:0]     quotient_q,  quotient_d;
    logic [W-1:0]     remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;

    logic [W:0]       rem_shift;

    // NOTE: every signal driven here gets a default first. That way no path
    // leaves it unassigned, and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        rem_shift   = {rem_q, op_a_q[W-1]};

        case (state_q)
            S_IDLE: begin
                if (i_in_valid) begin
                    op_a_d   = i_dividend;
                    op_b_d   = i_divisor;
                    sign_a_d = i_dividend[W-1];
                    sign_b_d = i_divisor[W-1];
                    if (i_divisor == '0) begin
                        // Saturate toward the sign of the dividend, and pass
                        // the dividend through as the remainder.
                        quotient_d  = i_dividend[W-1] ? MIN_NEG : MAX_POS;
                        remainder_d = i_dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = S_ABS;
                    end
                end
            end

            S_ABS: begin
                // The magnitude of the most negative value (2^(W-1)) still
                // fits, because the register is treated as unsigned from here.
                op_a_d  = sign_a_q ? -op_a_q : op_a_q;
                op_b_d  = sign_b_q ? -op_b_q : op_b_q;
                rem_d   = '0;
                quo_d   = '0;
                cnt_d   = CNT_W'(W - 1);
                state_d = S_CALC;
            end

            S_CALC: begin
                if (rem_shift >= {1'b0, op_b_q}) begin
                    rem_d = W'(rem_shift - {1'b0, op_b_q});
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[W-1:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                op_a_d = op_a_q << 1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            S_FIX: begin
                // min_neg / -1 yields a magnitude of 2^(W-1). Negating it in
                // W bits wraps back to min_neg, which is the defined result.
                quotient_d  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
                remainder_d = sign_a_q ? -rem_q : rem_q;
                state_d     = S_DONE;
            end

            S_DONE: begin
                if (i_out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments. Every flop then
    // samples the values from before the edge, whatever order the lines are in.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            // NOTE: every register, including the datapath, is cleared on
            // reset. That way an aborted division leaves nothing behind.
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign o_in_ready    = (state_q == S_IDLE);
    assign o_out_valid   = (state_q == S_DONE);
    assign o_quotient    = quotient_q;
    assign o_remainder   = remainder_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_dsp_div.sv
// -----------------------------------------------------------------------------
// tb_dsp_div
// Self-checking bench for dsp_div (VALUE_WIDTH = 17). It covers:
//   - the reset state and the directed sign and edge cases, with latency
//   - backpressure, and an abort by reset in the middle of a division
//   - randomised back-to-back divisions against an arithmetic reference model
// -----------------------------------------------------------------------------
module tb_dsp_div;

    localparam int W       = 17;
    localparam int NORM_LAT = W + 2;   // edges after the accept edge
    localparam int N_RAND  = 1000;

    logic         i_clk       = 1'b0;
    logic         i_aresetn   = 1'b1;
    logic         i_in_valid  = 1'b0;
    logic         i_out_ready = 1'b1;
    logic [W-1:0] i_dividend  = '0;
    logic [W-1:0] i_divisor   = '0;
    logic         o_in_ready;
    logic         o_out_valid;
    logic [W-1:0] o_quotient;
    logic [W-1:0] o_remainder;
    logic         o_div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    dsp_div #(.VALUE_WIDTH(W)) dut (
        .i_clk         (i_clk),
        .i_aresetn     (i_aresetn),
        .i_in_valid    (i_in_valid),
        .o_in_ready    (o_in_ready),
        .i_dividend    (i_dividend),
        .i_divisor     (i_divisor),
        .o_out_valid   (o_out_valid),
        .i_out_ready   (i_out_ready),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // Reference: plain integer division (truncating toward zero). The quotient
    // is wrapped to W bits, and a zero divisor saturates.
    function automatic void ref_div(input longint a, input longint b,
                                    output longint q, output longint r,
                                    output longint f);
        if (b == 0) begin
            q = (a >= 0) ? (longint'(1) << (W - 1)) - 1 : -(longint'(1) << (W - 1));
            r = a;
            f = 1;
        end else begin
            q = a / b;
            r = a % b;
            f = 0;
            if (q > (longint'(1) << (W - 1)) - 1) q = q - (longint'(1) << W);
        end
    endfunction

    // Present one operand pair and return #1 after the accepting edge. The
    // operand buses are then scrambled, since the DUT must use its own copies.
    task automatic start_op(input longint a, input longint b);
        int guard;
        guard = 0;
        @(negedge i_clk);
        while (!o_in_ready && guard < 100) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_in_ready) check("accept_timeout", longint'(o_in_ready), 1);
        i_in_valid = 1'b1;
        i_dividend = W'(a);
        i_divisor  = W'(b);
        @(posedge i_clk);
        #1;
        i_in_valid = 1'b0;
        i_dividend = W'($urandom);
        i_divisor  = W'($urandom);
    endtask

    // Count the edges after the accept edge until o_out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!o_out_valid && lat < 100) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        if (!o_out_valid) check("valid_timeout", longint'(o_out_valid), 1);
    endtask

    // Run a division with i_out_ready high. Check the latency and result
    // against the given values, then let the handshake edge go by.
    task automatic run_checked(input string tag, input longint a, input longint b,
                               input longint eq, input longint er, input longint ef,
                               input int elat);
        int lat;
        start_op(a, b);
        wait_valid(lat);
        check({tag, "_lat"}, lat, elat);
        check({tag, "_q"}, sx(o_quotient), eq);
        check({tag, "_r"}, sx(o_remainder), er);
        check({tag, "_dbz"}, longint'(o_div_by_zero), ef);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int lat;
        longint a, b, eq, er, ef;
        logic [W-1:0] ra, rb;

        // ---------------- reset state ----------------
        #3 i_aresetn = 1'b0;
        #1;
        check("rst_in_ready", longint'(o_in_ready), 1);
        check("rst_out_valid", longint'(o_out_valid), 0);
        check("rst_q", sx(o_quotient), 0);
        check("rst_r", sx(o_remainder), 0);
        check("rst_dbz", longint'(o_div_by_zero), 0);
        repeat (2) @(negedge i_clk);
        i_aresetn = 1'b1;

        // ---------------- directed cases ----------------
        // Divide-by-zero results are visible right after the accepting edge.
        run_checked("p100_p7",   100,     7,     14,     2,      0, NORM_LAT);
        run_checked("m100_p7",   -100,    7,     -14,    -2,     0, NORM_LAT);
        run_checked("p100_m7",   100,     -7,    -14,    2,      0, NORM_LAT);
        run_checked("m100_m7",   -100,    -7,    14,     -2,     0, NORM_LAT);
        run_checked("p5_zero",   5,       0,     65535,  5,      1, 0);
        run_checked("m5_zero",   -5,      0,     -65536, -5,     1, 0);
        run_checked("min_m1",    -65536,  -1,    -65536, 0,      0, NORM_LAT);
        run_checked("zero_p3",   0,       3,     0,      0,      0, NORM_LAT);
        run_checked("min_p1",    -65536,  1,     -65536, 0,      0, NORM_LAT);
        run_checked("max_min",   65535,   -65536, 0,     65535,  0, NORM_LAT);
        run_checked("min_min",   -65536,  -65536, 1,     0,      0, NORM_LAT);
        run_checked("min_zero",  -65536,  0,     -65536, -65536, 1, 0);
        run_checked("zero_zero", 0,       0,     65535,  0,      1, 0);

        // ---------------- backpressure ----------------
        // 1234 / -17: 17*72 = 1224, so q = -72 and r = 10.
        i_out_ready = 1'b0;
        start_op(1234, -17);
        wait_valid(lat);
        check("bp_lat", lat, NORM_LAT);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                i_in_valid = 1'b1;
                i_dividend = W'(50);
                i_divisor  = W'(5);
            end
            if (i == 8) i_in_valid = 1'b0;
            @(posedge i_clk);
            #1;
            check("bp_valid", longint'(o_out_valid), 1);
            check("bp_in_ready", longint'(o_in_ready), 0);
            check("bp_q", sx(o_quotient), -72);
            check("bp_r", sx(o_remainder), 10);
        end
        @(negedge i_clk);
        i_out_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("bp_release_in_ready", longint'(o_in_ready), 1);
        check("bp_release_valid", longint'(o_out_valid), 0);
        repeat (3) @(posedge i_clk);
        #1;
        check("bp_no_accept", longint'(o_in_ready), 1);
        check("bp_retain_q", sx(o_quotient), -72);
        check("bp_retain_r", sx(o_remainder), 10);

        // ---------------- reset in the middle of CALC ----------------
        start_op(1000, 3);
        repeat (8) @(posedge i_clk);
        #2;
        i_aresetn = 1'b0;
        #1;
        check("abort_in_ready", longint'(o_in_ready), 1);
        check("abort_valid", longint'(o_out_valid), 0);
        check("abort_q", sx(o_quotient), 0);
        check("abort_r", sx(o_remainder), 0);
        check("abort_dbz", longint'(o_div_by_zero), 0);
        @(negedge i_clk);
        i_aresetn = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("abort_no_result", longint'(o_out_valid), 0);
        run_checked("after_abort", 1000, 3, 333, 1, 0, NORM_LAT);

        // ---------------- randomised back-to-back ----------------
        for (int n = 0; n < N_RAND; n++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1:       rb = W'(-1);
                2:       rb = W'($urandom_range(1, 15));
                3:       rb = W'(-$urandom_range(1, 15));
                4:       begin ra = {1'b1, {(W-1){1'b0}}}; rb = W'($urandom); end
                default: rb = W'($urandom);
            endcase
            a = sx(ra);
            b = sx(rb);
            ref_div(a, b, eq, er, ef);
            start_op(a, b);
            wait_valid(lat);
            check($sformatf("rand_q %0d/%0d", a, b), sx(o_quotient), eq);
            check($sformatf("rand_r %0d/%0d", a, b), sx(o_remainder), er);
            check($sformatf("rand_dbz %0d/%0d", a, b), longint'(o_div_by_zero), ef);
            @(posedge i_clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
